// File: rtl/snax_shell_csr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : snax_shell_csr_ctrl
// Description : CSR / launch controller for SNAX accelerator shells.
//               Queues configuration sets so the host can program job N+1
//               while job N runs, produces a registered busy flag, a
//               busy-cycle performance counter and per-stream beat counters
//               (plus optional per-stream stall counters), all exported as
//               read-only CSRs.
// Ports       : clk_i / rst_ni          clock, asynchronous active-low reset
//               csr_reg_set_*           config set from the CSR manager
//               core_cfg_*              FIFO head towards the core config port
//               core_busy_i             busy flag from the accelerator core
//               strm_valid_i/ready_i    monitored stream handshakes
//               busy_o, cfg_pending_o   status CSRs
//               perf_cycles_o           busy-cycle counter
//               beat_cnt_o, stall_cnt_o per-stream counters (CNT_WIDTH each)
// Options     : SNAX_SHELL_STALL_CNT_EN  when defined, generates the stall
//               counters; otherwise stall_cnt_o is tied to zero.
// Revision    : 1.0  initial release
// ============================================================================
module snax_shell_csr_ctrl #(
    parameter int NUM_CFG_REGS   = 6,
    parameter int REG_DATA_WIDTH = 32,
    parameter int CFG_FIFO_DEPTH = 2,   // legal range 1..8
    parameter int NUM_STREAMS    = 4,
    parameter int CNT_WIDTH      = 32   // must not exceed REG_DATA_WIDTH
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NUM_CFG_REGS*REG_DATA_WIDTH-1:0] csr_reg_set_i,
    input  logic                                   csr_reg_set_valid_i,
    output logic                                   csr_reg_set_ready_o,
    output logic [NUM_CFG_REGS*REG_DATA_WIDTH-1:0] core_cfg_o,
    output logic                                   core_cfg_valid_o,
    input  logic                                   core_cfg_ready_i,
    input  logic                                   core_busy_i,
    input  logic [NUM_STREAMS-1:0]                 strm_valid_i,
    input  logic [NUM_STREAMS-1:0]                 strm_ready_i,
    output logic                                   busy_o,
    output logic [3:0]                             cfg_pending_o,
    output logic [CNT_WIDTH-1:0]                   perf_cycles_o,
    output logic [NUM_STREAMS*CNT_WIDTH-1:0]       beat_cnt_o,
    output logic [NUM_STREAMS*CNT_WIDTH-1:0]       stall_cnt_o
);

    localparam int             c_cfg_w    = NUM_CFG_REGS * REG_DATA_WIDTH;
    localparam int             c_ptr_w    = (CFG_FIFO_DEPTH > 1) ? $clog2(CFG_FIFO_DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(CFG_FIFO_DEPTH - 1);
    localparam logic [3:0]     c_depth    = 4'(CFG_FIFO_DEPTH);

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    // ------------------------------------------------------------------
    // Configuration FIFO
    // ------------------------------------------------------------------
    logic [c_cfg_w-1:0] r_mem [CFG_FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [3:0]         r_count;
    logic               r_launch_gap;
    logic               r_busy;

    logic w_full;
    logic w_not_empty;
    logic w_push;
    logic w_pop;
    logic w_win_start;

    assign w_full      = (r_count == c_depth);
    assign w_not_empty = (r_count != 4'd0);
    // Ready depends only on the registered count: a pop in the same cycle
    // never opens a slot for a push.
    assign w_push      = csr_reg_set_valid_i & ~w_full;
    assign w_pop       = w_not_empty & core_cfg_ready_i;
    // A job window opens only when the shell is fully idle; pushes that
    // arrive while busy fold into the running window.
    assign w_win_start = w_push & ~r_busy & ~w_not_empty;

    assign csr_reg_set_ready_o = ~w_full;
    assign core_cfg_valid_o    = w_not_empty;
    assign core_cfg_o          = r_mem[r_rd_ptr];
    assign cfg_pending_o       = r_count;
    assign busy_o              = r_busy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < CFG_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= csr_reg_set_i;
                r_wr_ptr        <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Busy flag: the launch gap bridges the cycle between popping a config
    // and the core raising its own busy flag, so busy_o never dips there.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_launch_gap <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_launch_gap <= w_pop;
            r_busy       <= w_not_empty | core_busy_i | r_launch_gap;
        end
    end

    // ------------------------------------------------------------------
    // Performance counter (clear beats increment)
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] r_perf_cycles;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_cycles <= '0;
        end else if (w_win_start) begin
            r_perf_cycles <= '0;
        end else if (r_busy) begin
            r_perf_cycles <= sat_inc(r_perf_cycles);
        end
    end

    assign perf_cycles_o = r_perf_cycles;

    // ------------------------------------------------------------------
    // Per-stream beat counters (count regardless of busy state)
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_beat
            logic [CNT_WIDTH-1:0] r_beat;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_beat <= '0;
                end else if (w_win_start) begin
                    r_beat <= '0;
                end else if (strm_valid_i[g] & strm_ready_i[g]) begin
                    r_beat <= sat_inc(r_beat);
                end
            end

            assign beat_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = r_beat;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Optional per-stream stall counters
    // ------------------------------------------------------------------
`ifdef SNAX_SHELL_STALL_CNT_EN
    generate
        for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_stall
            logic [CNT_WIDTH-1:0] r_stall;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_stall <= '0;
                end else if (w_win_start) begin
                    r_stall <= '0;
                end else if (strm_valid_i[g] & ~strm_ready_i[g]) begin
                    r_stall <= sat_inc(r_stall);
                end
            end

            assign stall_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = r_stall;
        end
    endgenerate
`else
    assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire
